// File: rtl/pipelined_datapath_if.sv
// Issue/result handshake bundle between the issue logic (master) and the
// pipelined register-file + ALU datapath (slave).
interface pipelined_datapath_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   read_reg_num1;
  logic [AW-1:0]   read_reg_num2;
  logic [AW-1:0]   write_reg;
  logic [3:0]      alu_control;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic            regwrite;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   out_reg;
  logic            zero_flag;

  modport master (
    output in_valid, read_reg_num1, read_reg_num2, write_reg, alu_control,
           use_imm, imm, regwrite, out_ready,
    input  in_ready, out_valid, result, out_reg, zero_flag
  );

  modport slave (
    input  in_valid, read_reg_num1, read_reg_num2, write_reg, alu_control,
           use_imm, imm, regwrite, out_ready,
    output in_ready, out_valid, result, out_reg, zero_flag
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage register file + ALU: operand stage with EX->read forwarding,
// then execute/commit stage feeding a valid/ready result port.
module pipelined_datapath #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  pipelined_datapath_if.slave dp
);
  localparam int AW  = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      ALU_AND:  alu_op = a & b;
      ALU_OR:   alu_op = a | b;
      ALU_ADD:  alu_op = a + b;
      ALU_SUB:  alu_op = a - b;
      ALU_XOR:  alu_op = a ^ b;
      ALU_SLT:  alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: alu_op = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_op = a << sh;
      ALU_SRL:  alu_op = a >> sh;
      ALU_SRA:  alu_op = sa >>> sh;
      ALU_NOR:  alu_op = ~(a | b);
      default:  alu_op = '0;
    endcase
  endfunction

  logic [XLEN-1:0] regs [NREGS];

  logic            vld_p1, regwrite_p1;
  logic [XLEN-1:0] op_a_p1, op_b_p1;
  logic [3:0]      alu_ctl_p1;
  logic [AW-1:0]   rd_p1;
  logic [XLEN-1:0] alu_p1;

  logic            vld_p2, zero_p2;
  logic [XLEN-1:0] result_p2;
  logic [AW-1:0]   rd_p2;

  logic            advance, accept, commit;
  logic            fwd_a, fwd_b;
  logic [AW-1:0]   rs_a, rs_b;
  logic [XLEN-1:0] rf_a, rf_b, opnd_a, opnd_b;

  assign advance     = !vld_p2 | dp.out_ready;
  assign dp.in_ready = advance & !reset;
  assign accept      = dp.in_valid & dp.in_ready;
  assign alu_p1      = alu_op(alu_ctl_p1, op_a_p1, op_b_p1);

  // read stage: the S1 op is not yet committed, so its result is bypassed
  assign rs_a   = dp.read_reg_num1;
  assign rs_b   = dp.read_reg_num2;
  assign rf_a   = (ZERO_REG && rs_a == '0) ? '0 : regs[rs_a];
  assign rf_b   = (ZERO_REG && rs_b == '0) ? '0 : regs[rs_b];
  assign fwd_a  = vld_p1 & regwrite_p1 & (rd_p1 == rs_a) & (!ZERO_REG || rs_a != '0);
  assign fwd_b  = vld_p1 & regwrite_p1 & (rd_p1 == rs_b) & (!ZERO_REG || rs_b != '0);
  assign opnd_a = fwd_a ? alu_p1 : rf_a;
  assign opnd_b = dp.use_imm ? dp.imm : (fwd_b ? alu_p1 : rf_b);
  assign commit = advance & vld_p1 & regwrite_p1 & (!ZERO_REG || rd_p1 != '0);

  always_ff @(posedge clock) begin
    if (accept) begin
      op_a_p1     <= opnd_a;
      op_b_p1     <= opnd_b;
      alu_ctl_p1  <= dp.alu_control;
      rd_p1       <= dp.write_reg;
      regwrite_p1 <= dp.regwrite;
    end
  end

  // execute/commit stage: S1 -> S2 and regfile write share the advance edge
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      rd_p2     <= '0;
      zero_p2   <= 1'b1;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (advance) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= alu_p1;
        rd_p2     <= rd_p1;
        zero_p2   <= (alu_p1 == '0);
      end
      if (commit) regs[rd_p1] <= alu_p1;
    end
  end

  assign dp.out_valid = vld_p2;
  assign dp.result    = result_p2;
  assign dp.out_reg   = rd_p2;
  assign dp.zero_flag = zero_p2;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Drives a 32x32 (x0 hardwired) and an 8x16 (ordinary r0) datapath in lockstep
// and compares both against an in-order architectural model.
module tb_pipelined_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, use_imm, regwrite;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  op;
  logic [31:0] imm;

  pipelined_datapath_if #(.XLEN(32), .NREGS(32)) ifa ();
  pipelined_datapath_if #(.XLEN(16), .NREGS(8))  ifb ();

  assign ifa.in_valid      = in_valid;
  assign ifa.read_reg_num1 = rs1;
  assign ifa.read_reg_num2 = rs2;
  assign ifa.write_reg     = rd;
  assign ifa.alu_control   = op;
  assign ifa.use_imm       = use_imm;
  assign ifa.imm           = imm;
  assign ifa.regwrite      = regwrite;
  assign ifa.out_ready     = out_ready;

  assign ifb.in_valid      = in_valid;
  assign ifb.read_reg_num1 = rs1[2:0];
  assign ifb.read_reg_num2 = rs2[2:0];
  assign ifb.write_reg     = rd[2:0];
  assign ifb.alu_control   = op;
  assign ifb.use_imm       = use_imm;
  assign ifb.imm           = imm[15:0];
  assign ifb.regwrite      = regwrite;
  assign ifb.out_ready     = out_ready;

  pipelined_datapath #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1)) dut_a (
    .clock(clk), .reset(rst), .dp(ifa));
  pipelined_datapath #(.XLEN(16), .NREGS(8), .ZERO_REG(1'b0)) dut_b (
    .clock(clk), .reset(rst), .dp(ifb));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma[32];
  logic [15:0] mb[8];
  logic [31:0] dres[$];
  logic        dzf[$];
  int          dcyc[$];

  logic [3:0] op_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h7,
                              4'h3, 4'h8, 4'h9, 4'hA, 4'hC, 4'hF};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [63:0] a,
                                          input logic [63:0] b, input int xl);
    logic [63:0]        mask, r;
    logic signed [63:0] sa, sb;
    int                 sh;
    mask = (64'd1 << xl) - 64'd1;
    sa   = a[xl-1] ? $signed(a | ~mask) : $signed(a);
    sb   = b[xl-1] ? $signed(b | ~mask) : $signed(b);
    sh   = int'(b % 64'(xl));
    case (o)
      4'h0:    r = a & b;
      4'h1:    r = a | b;
      4'h2:    r = a + b;
      4'h6:    r = a - b;
      4'h4:    r = a ^ b;
      4'h7:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'h3:    r = (a < b) ? 64'd1 : 64'd0;
      4'h8:    r = a << sh;
      4'h9:    r = a >> sh;
      4'hA:    r = sa >>> sh;
      4'hC:    r = ~(a | b);
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  // architectural model: every accepted op executes immediately, in order
  logic        ha, hb, pa_zf, pb_zf;
  logic [63:0] va, vb, r, pa_res, pb_res, pa_reg, pb_reg;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < 32; i++) ma[i] = '0;
      for (int i = 0; i < 8; i++)  mb[i] = '0;
      ha = 1'b0;
      hb = 1'b0;
    end else begin
      chk("in_ready_rule_a", 64'(ifa.in_ready), 64'(!ifa.out_valid | out_ready));
      chk("in_ready_rule_b", 64'(ifb.in_ready), 64'(!ifb.out_valid | out_ready));
      if (ha) begin
        chk("hold_result_a", 64'(ifa.result), pa_res);
        chk("hold_out_reg_a", 64'(ifa.out_reg), pa_reg);
        chk("hold_zero_a", 64'(ifa.zero_flag), 64'(pa_zf));
      end
      if (hb) begin
        chk("hold_result_b", 64'(ifb.result), pb_res);
        chk("hold_out_reg_b", 64'(ifb.out_reg), pb_reg);
        chk("hold_zero_b", 64'(ifb.zero_flag), 64'(pb_zf));
      end
      if (in_valid && ifa.in_ready) begin
        va = 64'(ma[rs1]);
        vb = use_imm ? 64'(imm) : 64'(ma[rs2]);
        r  = ref_alu(op, va, vb, 32);
        if (regwrite && rd != 5'd0) ma[rd] = r[31:0];
        qa.push_back('{res: r, rd: rd});
        va = 64'(mb[rs1[2:0]]);
        vb = use_imm ? 64'(imm[15:0]) : 64'(mb[rs2[2:0]]);
        r  = ref_alu(op, va, vb, 16);
        if (regwrite) mb[rd[2:0]] = r[15:0];
        qb.push_back('{res: r, rd: {2'b00, rd[2:0]}});
      end
      if (ifa.out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("spurious_out_a", 64'(ifa.out_valid), 64'd0);
        end else begin
          e = qa.pop_front();
          chk("result_a", 64'(ifa.result), e.res);
          chk("out_reg_a", 64'(ifa.out_reg), 64'(e.rd));
          chk("zero_a", 64'(ifa.zero_flag), 64'(e.res == 64'd0));
          dres.push_back(ifa.result);
          dzf.push_back(ifa.zero_flag);
          dcyc.push_back(cyc);
        end
      end
      if (ifb.out_valid && out_ready) begin
        if (qb.size() == 0) begin
          chk("spurious_out_b", 64'(ifb.out_valid), 64'd0);
        end else begin
          e = qb.pop_front();
          chk("result_b", 64'(ifb.result), e.res);
          chk("out_reg_b", 64'(ifb.out_reg), 64'(e.rd));
          chk("zero_b", 64'(ifb.zero_flag), 64'(e.res == 64'd0));
        end
      end
      ha = ifa.out_valid & !out_ready;
      hb = ifb.out_valid & !out_ready;
      pa_res = 64'(ifa.result); pa_reg = 64'(ifa.out_reg); pa_zf = ifa.zero_flag;
      pb_res = 64'(ifb.result); pb_reg = 64'(ifb.out_reg); pb_zf = ifb.zero_flag;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic [3:0] o, input logic ui, input logic [31:0] im,
                       input logic rw);
    logic ok;
    ok = 1'b0;
    rs1 = a1; rs2 = a2; rd = d; op = o; use_imm = ui; imm = im; regwrite = rw;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("issue_accepted", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    dres.delete();
    dzf.delete();
    dcyc.delete();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] exp);
    chk(nm, (idx < dres.size()) ? 64'(dres[idx]) : 64'hDEAD_0000_0000_0000, 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    in_valid = 1'b0; out_ready = 1'b1; use_imm = 1'b0; regwrite = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; op = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid_a", 64'(ifa.out_valid), 64'd0);
    chk("reset_zero_a", 64'(ifa.zero_flag), 64'd1);
    chk("reset_result_a", 64'(ifa.result), 64'd0);
    chk("reset_out_reg_a", 64'(ifa.out_reg), 64'd0);
    chk("reset_zero_b", 64'(ifb.zero_flag), 64'd1);
    chk("reset_in_ready_a", 64'(ifa.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // ADD r1 = r0 + 5, one-cycle latency
    issue(5'd0, 5'd0, 5'd1, 4'h2, 1'b1, 32'd5, 1'b1);
    chk("lat_not_yet_valid", 64'(ifa.out_valid), 64'd0);
    step(1);
    chk("lat_out_valid", 64'(ifa.out_valid), 64'd1);
    chk("lat_result", 64'(ifa.result), 64'd5);
    chk("lat_out_reg", 64'(ifa.out_reg), 64'd1);
    step(1);
    clear_log();

    // back-to-back dependent ops through the bypass
    issue(5'd1, 5'd0, 5'd2, 4'h2, 1'b1, 32'd3, 1'b1);
    issue(5'd2, 5'd1, 5'd3, 4'h6, 1'b0, 32'd0, 1'b1);
    step(3);
    chk("fwd_count", 64'(dres.size()), 64'd2);
    chk_log("fwd_add", 0, 32'd8);
    chk_log("fwd_sub", 1, 32'd3);
    gap = (dcyc.size() >= 2) ? dcyc[1] - dcyc[0] : -1;
    chk("fwd_no_bubble", 64'(gap), 64'd1);
    clear_log();

    // writes to x0 are dropped and never forwarded
    issue(5'd0, 5'd0, 5'd0, 4'h2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    issue(5'd0, 5'd0, 5'd6, 4'h2, 1'b1, 32'd0, 1'b1);
    step(2);
    issue(5'd0, 5'd0, 5'd7, 4'h1, 1'b0, 32'd0, 1'b1);
    step(3);
    chk_log("x0_write_result", 0, 32'hFFFF_FFFF);
    chk_log("x0_no_forward", 1, 32'd0);
    chk_log("x0_reads_zero", 2, 32'd0);
    chk("x0_zero_flag", (dzf.size() > 2) ? 64'(dzf[2]) : 64'd0, 64'd1);
    clear_log();

    // backpressure with two ops in flight
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd4, 4'h2, 1'b1, 32'd7, 1'b1);
    issue(5'd4, 5'd0, 5'd5, 4'h2, 1'b1, 32'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(ifa.in_ready), 64'd0);
      chk("stall_out_valid", 64'(ifa.out_valid), 64'd1);
      chk("stall_result", 64'(ifa.result), 64'd7);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    step(3);
    chk("stall_count", 64'(dres.size()), 64'd2);
    chk_log("stall_first", 0, 32'd7);
    chk_log("stall_second", 1, 32'd8);
    clear_log();

    // compare, shift and undefined opcodes
    issue(5'd0, 5'd0, 5'd8, 4'h2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    issue(5'd8, 5'd0, 5'd9, 4'h7, 1'b1, 32'd1, 1'b1);
    issue(5'd8, 5'd0, 5'd9, 4'h3, 1'b1, 32'd1, 1'b1);
    issue(5'd0, 5'd0, 5'd10, 4'h2, 1'b1, 32'h8000_0000, 1'b1);
    issue(5'd10, 5'd0, 5'd11, 4'hA, 1'b1, 32'd4, 1'b1);
    issue(5'd8, 5'd0, 5'd12, 4'hF, 1'b1, 32'd1, 1'b1);
    step(3);
    chk("ops_count", 64'(dres.size()), 64'd6);
    chk_log("slt_signed", 1, 32'd1);
    chk_log("sltu", 2, 32'd0);
    chk_log("sra", 4, 32'hF800_0000);
    chk_log("undef_op", 5, 32'd0);
    chk("undef_zero_flag", (dzf.size() > 5) ? 64'(dzf[5]) : 64'd0, 64'd1);
    chk("slt_zero_flag", (dzf.size() > 1) ? 64'(dzf[1]) : 64'd1, 64'd0);
    clear_log();

    // randomized traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rs1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      op  = ($urandom_range(0, 7) != 0) ? op_tab[$urandom_range(0, 11)] : 4'($urandom_range(0, 15));
      use_imm  = ($urandom_range(0, 1) != 0);
      regwrite = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 40));
        2:       imm = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: imm = 32'h8000_0000;
      endcase
      step(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(4);
    chk("rand_drained_a", 64'(qa.size()), 64'd0);
    chk("rand_drained_b", 64'(qb.size()), 64'd0);

    // reset with both stages occupied
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd1, 4'h2, 1'b1, 32'd9, 1'b1);
    issue(5'd1, 5'd0, 5'd2, 4'h2, 1'b1, 32'd1, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid_a", 64'(ifa.out_valid), 64'd0);
    chk("rst2_out_valid_b", 64'(ifb.out_valid), 64'd0);
    chk("rst2_result_a", 64'(ifa.result), 64'd0);
    chk("rst2_zero_a", 64'(ifa.zero_flag), 64'd1);
    chk("rst2_out_reg_a", 64'(ifa.out_reg), 64'd0);
    @(posedge clk);
    #1;
    clear_log();
    issue(5'd1, 5'd0, 5'd13, 4'h2, 1'b1, 32'd0, 1'b1);
    issue(5'd2, 5'd0, 5'd14, 4'h2, 1'b1, 32'd0, 1'b1);
    issue(5'd8, 5'd0, 5'd15, 4'h2, 1'b1, 32'd0, 1'b1);
    step(3);
    chk("rst2_count", 64'(dres.size()), 64'd3);
    chk_log("rst2_r1", 0, 32'd0);
    chk_log("rst2_r2", 1, 32'd0);
    chk_log("rst2_r8", 2, 32'd0);

    step(2);
    chk("final_drained_a", 64'(qa.size()), 64'd0);
    chk("final_drained_b", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
